backoff_lock_resp: RTL
======================

// Module: backoff_lock_resp
// PURPOSE
// - Responder side of the randomized-retry protocol: arbitrates one shared lock among NumReq initiators.
// - Each initiator owns an exp_backoff instance and issues acquire trials.
// - Each trial is answered ok (drives the initiator's clr_i) or fail (drives set_i).
// - Collisions fail every contender, like Ethernet; the initiators' randomized backoff resolves them.
// - A lease timer reclaims locks whose owner never releases.
// PARAMETERS
// - NumReq       4    number of initiators, 2..32
// - LeaseCycles  256  cycles a lock may be held before forced release; 0 = lease disabled
// - IdxWidth     derived localparam, $clog2(NumReq)
// PORTS
// - clk_i        in   1         clock
// - rst_ni       in   1         asynchronous active-low reset
// - clear_i      in   1         synchronous clear; same effect as reset, takes priority over all other inputs
// - acq_i        in   NumReq    per-initiator acquire trial (pulse)
// - rel_i        in   NumReq    per-initiator release (pulse)
// - resp_valid_o out  NumReq    trial response valid, one cycle after acq_i
// - resp_ok_o    out  NumReq    1 = trial succeeded, 0 = failed; meaningful only with resp_valid_o
// - locked_o     out  1         lock currently held
// - owner_o      out  IdxWidth  current owner index; '0 when free
// - expired_o    out  1         pulse: lease expired, lock force-freed
// - err_o        out  1         pulse: release from a non-owner or while free
// BEHAVIOUR
// - Reset/clear values: all outputs 0, state FREE, owner 0, lease count 0.
// - States: FREE, HELD. All responses are registered; latency is exactly 1 cycle.
// - Every acq_i bit set in cycle t yields a resp_valid_o bit in cycle t+1.
// - Acquire decisions are evaluated against the state at cycle t, before any release or expiry in the same cycle takes effect.
// - FREE:
//   - exactly one acq_i bit set: that initiator gets ok.
//   - Next state HELD, owner = its index, lease = LeaseCycles.
//   - more than one bit set: all contenders fail; stay FREE.
// - HELD:
//   - acq from the owner: ok (idempotent).
//   - The lease is not reloaded.
//   - acq from any other initiator: fail.
// - Release:
//   - rel_i from the owner in HELD: next state FREE, owner 0.
//   - Any other rel_i bit, or any rel_i while FREE: ignored, err_o pulses for 1 cycle.
// - Simultaneous events:
//   - owner rel plus other acq in the same cycle: the acqs fail.
//   - The lock is FREE in the next cycle.
//   - acq and rel on the same initiator while it owns the lock: acq ok, release taken, FREE next.
// - Lease (LeaseCycles > 0):
//   - the counter decrements each cycle in HELD.
//   - When it reaches 1 and no release arrives, the next state is FREE and expired_o pulses.
//   - If the owner releases in that same cycle, the release wins and expired_o stays 0.
//   - LeaseCycles = 0: no counter is instantiated; the lock is held until released.
// - Widths: the lease counter is $clog2(LeaseCycles+1) bits. Its count never wraps.
// CONFIGURATION
// - BACKOFF_LOCK_STATS_EN defined:
//   - adds outputs stat_grants_o[31:0] and stat_collisions_o[31:0], both saturating at all-ones.
//   - stat_grants_o counts successful FREE->HELD grants; stat_collisions_o counts FREE cycles with more than one acq.
//   - Both are cleared by reset and clear_i.
// - BACKOFF_LOCK_STATS_EN undefined: no counters and no stat ports. Core behaviour is identical in both cases.
// STRUCTURE
// - Package backoff_lock_pkg:
//   - lock_state_e {FREE, HELD}
//   - function popcount_gt1(logic [31:0])
//   - function onehot_to_idx
// - Sub-module backoff_lock_lease: loadable down-counter with load, en, clear and expire pulse.
//   - It is generated only when LeaseCycles > 0.
// - Registers use the common_cells FFC-style macros (async reset, sync clear).
// TESTING
// - Single contender:
//   - FREE, acq_i=4'b0100 -> next cycle resp_valid_o=4'b0100, resp_ok_o=4'b0100.
//   - Afterwards locked_o=1, owner_o=2.
// - Collision: FREE, acq_i=4'b0011 -> resp_valid_o=4'b0011, resp_ok_o=4'b0000; locked_o stays 0.
// - Owner release with a contender: owner 2, rel_i=4'b0100 and acq_i=4'b0001 together.
//   - Result: resp_ok_o[0]=0, locked_o=0 next cycle, and acq 0 retried later succeeds.
// - Bad release: FREE, rel_i=4'b1000 -> err_o=1 for one cycle; state unchanged.
// - Lease expiry: LeaseCycles=8, grant at cycle 0 with no release.
//   - expired_o=1 and locked_o falls exactly 8 cycles after locked_o rises.
//   - A release in the expiry cycle suppresses expired_o.
// - Reset mid-hold: rst_ni low while HELD -> all outputs 0 asynchronously.
//   - Same check for clear_i, which clears synchronously; stats are also cleared when BACKOFF_LOCK_STATS_EN is defined.

Source files
------------

// File: rtl/backoff_lock_pkg.sv
// Shared types and helpers for the backoff lock responder.
package backoff_lock_pkg;

  typedef enum logic [0:0] {
    FREE = 1'b0,
    HELD = 1'b1
  } lock_state_e;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic popcount_gt1(logic [31:0] x);
    return (x & (x - 32'd1)) != 32'd0;
  endfunction

  function automatic logic [4:0] onehot_to_idx(logic [31:0] x);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/backoff_lock_lease.sv
// Lease down-counter: loads on grant, counts while held, flags the final held cycle.
module backoff_lock_lease #(
  parameter  int LeaseCycles = 256,
  localparam int CntW        = $clog2(LeaseCycles + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CntW'(LeaseCycles);
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/backoff_lock_resp.sv
// Responder arbitrating one shared lock among NumReq retrying initiators.
// Optional BACKOFF_LOCK_STATS_EN adds saturating grant/collision counters.
module backoff_lock_resp
  import backoff_lock_pkg::*;
#(
  parameter  int NumReq      = 4,
  parameter  int LeaseCycles = 256,
  localparam int IdxWidth    = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [NumReq-1:0]   acq_i,
  input  logic [NumReq-1:0]   rel_i,
  output logic [NumReq-1:0]   resp_valid_o,
  output logic [NumReq-1:0]   resp_ok_o,
  output logic                locked_o,
  output logic [IdxWidth-1:0] owner_o,
  output logic                expired_o,
  output logic                err_o
`ifdef BACKOFF_LOCK_STATS_EN
  ,
  output logic [31:0]         stat_grants_o,
  output logic [31:0]         stat_collisions_o
`endif
);

  localparam logic [NumReq-1:0] OneHot0 = {{(NumReq-1){1'b0}}, 1'b1};

  lock_state_e         state_q, state_d;
  logic [IdxWidth-1:0] owner_q, owner_d;
  logic [NumReq-1:0]   valid_q, ok_q, ok_d;
  logic                expired_q, err_q;

  logic [31:0]         acq_ext;
  logic [NumReq-1:0]   owner_mask;
  logic                held, multi, grant, rel_take, lease_exp, expired_d, err_d;

  // Every decision below looks only at the registered state of this cycle.
  always_comb begin
    acq_ext              = '0;
    acq_ext[NumReq-1:0]  = acq_i;
    held                 = (state_q == HELD);
    owner_mask           = held ? (OneHot0 << owner_q) : '0;
    multi                = popcount_gt1(acq_ext);
    grant                = !held && (|acq_i) && !multi;
    ok_d                 = held ? (acq_i & owner_mask) : (grant ? acq_i : '0);
    rel_take             = held && |(rel_i & owner_mask);
    err_d                = |(rel_i & ~owner_mask);
    expired_d            = held && lease_exp && !rel_take;

    state_d = state_q;
    owner_d = owner_q;
    if (held) begin
      if (rel_take || lease_exp) begin
        state_d = FREE;
        owner_d = '0;
      end
    end else if (grant) begin
      state_d = HELD;
      owner_d = IdxWidth'(onehot_to_idx(acq_ext));
    end
  end

  generate
    if (LeaseCycles > 0) begin : g_lease
      backoff_lock_lease #(
        .LeaseCycles(LeaseCycles)
      ) u_lease (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i | rel_take),
        .load_i  (grant),
        .en_i    (held),
        .expire_o(lease_exp)
      );
    end else begin : g_no_lease
      assign lease_exp = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FREE;
      owner_q   <= '0;
      valid_q   <= '0;
      ok_q      <= '0;
      expired_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      state_q   <= FREE;
      owner_q   <= '0;
      valid_q   <= '0;
      ok_q      <= '0;
      expired_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      valid_q   <= acq_i;
      ok_q      <= ok_d;
      expired_q <= expired_d;
      err_q     <= err_d;
    end
  end

  assign resp_valid_o = valid_q;
  assign resp_ok_o    = ok_q;
  assign locked_o     = (state_q == HELD);
  assign owner_o      = owner_q;
  assign expired_o    = expired_q;
  assign err_o        = err_q;

`ifdef BACKOFF_LOCK_STATS_EN
  logic [31:0] grants_q, coll_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants_q <= '0;
      coll_q   <= '0;
    end else if (clear_i) begin
      grants_q <= '0;
      coll_q   <= '0;
    end else begin
      if (grant && grants_q != '1) grants_q <= grants_q + 32'd1;
      if (!held && multi && coll_q != '1) coll_q <= coll_q + 32'd1;
    end
  end

  assign stat_grants_o     = grants_q;
  assign stat_collisions_o = coll_q;
`endif

endmodule
